// File: rtl/i2c_mailbox_pkg.sv
// Shared register map, bit positions and helpers for the I2C mailbox register bank.
package i2c_mailbox_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t ADDR_ID        = 8'h00;
   localparam byte_t ADDR_STATUS    = 8'h01;
   localparam byte_t ADDR_CTRL      = 8'h02;
   localparam byte_t ADDR_H2L_DATA  = 8'h03;
   localparam byte_t ADDR_L2H_DATA  = 8'h04;
   localparam byte_t ADDR_H2L_LEVEL = 8'h05;
   localparam byte_t ADDR_L2H_LEVEL = 8'h06;
   localparam byte_t ADDR_ERR       = 8'h07;

   localparam int CTRL_H2L_FLUSH = 0;
   localparam int CTRL_L2H_FLUSH = 1;
   localparam int CTRL_IRQ_H2L   = 2;
   localparam int CTRL_IRQ_L2H   = 3;
   localparam int CTRL_IRQ_ERR   = 4;

   localparam int STAT_H2L_EMPTY = 0;
   localparam int STAT_H2L_FULL  = 1;
   localparam int STAT_L2H_EMPTY = 2;
   localparam int STAT_L2H_FULL  = 3;

   localparam int ERR_H2L_OVF = 0;
   localparam int ERR_L2H_UDF = 1;

   // A 256-deep FIFO holds 256 entries, one more than a byte can show.
   function automatic byte_t sat_level(input logic [8:0] count);
      return (count > 9'd255) ? 8'hFF : count[7:0];
   endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Circular-buffer byte FIFO with flush; push is refused when full, pop when empty.
module mailbox_fifo
   import i2c_mailbox_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  byte_t                    wdata,
   output byte_t                    rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   byte_t         mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   // Flush behaves like reset on the pointers and takes priority over traffic.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/i2c_mailbox_regs.sv
// Register bank with H2L/L2H mailbox FIFOs behind the I2C slave byte bus.
// Optional MAILBOX_IRQ_EN adds a registered level interrupt driven from CTRL[4:2].
module i2c_mailbox_regs
   import i2c_mailbox_pkg::*;
#(
   parameter int    DEPTH    = 16,
   parameter byte_t ID_VALUE = 8'hA5
) (
   input  logic  i_clk,
   input  logic  i_reset,
   input  logic  i_bus_cs,
   input  logic  i_bus_wr,
   input  byte_t i_bus_addr,
   input  byte_t i_bus_mosi,
   output byte_t o_bus_miso,
   output logic  o_h2l_valid,
   output byte_t o_h2l_data,
   input  logic  i_h2l_ready,
   input  logic  i_l2h_valid,
   input  byte_t i_l2h_data,
   output logic  o_l2h_ready,
   output byte_t o_ctrl,
   output logic  o_irq
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic          bus_wr;
   logic          bus_rd;
   logic          h2l_empty, h2l_full, l2h_empty, l2h_full;
   logic [LW-1:0] h2l_count, l2h_count;
   byte_t         l2h_head;
   logic          h2l_push, h2l_pop, h2l_flush;
   logic          l2h_push, l2h_pop, l2h_flush;
   byte_t         ctrl_q;
   logic [1:0]    err_q;
   logic [1:0]    err_set;
   logic [1:0]    err_clr;

   assign bus_wr = i_bus_cs & i_bus_wr;
   assign bus_rd = i_bus_cs & ~i_bus_wr;

   assign h2l_push  = bus_wr && (i_bus_addr == ADDR_H2L_DATA);
   assign h2l_pop   = o_h2l_valid & i_h2l_ready;
   assign h2l_flush = bus_wr && (i_bus_addr == ADDR_CTRL) && i_bus_mosi[CTRL_H2L_FLUSH];
   assign l2h_push  = i_l2h_valid & o_l2h_ready;
   assign l2h_pop   = bus_rd && (i_bus_addr == ADDR_L2H_DATA);
   assign l2h_flush = bus_wr && (i_bus_addr == ADDR_CTRL) && i_bus_mosi[CTRL_L2H_FLUSH];

   mailbox_fifo #(.DEPTH(DEPTH)) u_h2l (
      .clk   (i_clk),
      .reset (i_reset),
      .push  (h2l_push),
      .pop   (h2l_pop),
      .flush (h2l_flush),
      .wdata (i_bus_mosi),
      .rdata (o_h2l_data),
      .empty (h2l_empty),
      .full  (h2l_full),
      .level (h2l_count)
   );

   mailbox_fifo #(.DEPTH(DEPTH)) u_l2h (
      .clk   (i_clk),
      .reset (i_reset),
      .push  (l2h_push),
      .pop   (l2h_pop),
      .flush (l2h_flush),
      .wdata (i_l2h_data),
      .rdata (l2h_head),
      .empty (l2h_empty),
      .full  (l2h_full),
      .level (l2h_count)
   );

   assign o_h2l_valid = ~h2l_empty;
   assign o_l2h_ready = ~l2h_full;
   assign o_ctrl      = ctrl_q;

   // Error events win over a W1C clear landing in the same cycle.
   always_comb begin
      err_set = 2'b00;
      err_clr = 2'b00;
      err_set[ERR_H2L_OVF] = h2l_push & h2l_full;
      err_set[ERR_L2H_UDF] = l2h_pop & l2h_empty;
      if (bus_wr && (i_bus_addr == ADDR_ERR)) err_clr = i_bus_mosi[1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ctrl_q <= '0;
         err_q  <= '0;
      end else begin
         if (bus_wr && (i_bus_addr == ADDR_CTRL)) ctrl_q <= {i_bus_mosi[7:2], 2'b00};
         err_q <= (err_q & ~err_clr) | err_set;
      end
   end

   always_comb begin
      o_bus_miso = 8'h00;
      case (i_bus_addr)
         ADDR_ID:        o_bus_miso = ID_VALUE;
         ADDR_STATUS:    o_bus_miso = {4'b0000, l2h_full, l2h_empty, h2l_full, h2l_empty};
         ADDR_CTRL:      o_bus_miso = ctrl_q;
         ADDR_L2H_DATA:  o_bus_miso = l2h_empty ? 8'h00 : l2h_head;
         ADDR_H2L_LEVEL: o_bus_miso = sat_level(9'(h2l_count));
         ADDR_L2H_LEVEL: o_bus_miso = sat_level(9'(l2h_count));
         ADDR_ERR:       o_bus_miso = {6'b000000, err_q};
         default:        o_bus_miso = 8'h00;
      endcase
   end

`ifdef MAILBOX_IRQ_EN
   logic irq_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= (ctrl_q[CTRL_IRQ_H2L] & ~h2l_empty)
                | (ctrl_q[CTRL_IRQ_L2H] & l2h_empty)
                | (ctrl_q[CTRL_IRQ_ERR] & (|err_q));
      end
   end

   assign o_irq = irq_q;
`else
   assign o_irq = 1'b0;
`endif

endmodule
